// File: rtl/fsqrt_nr_seq.sv
// rtl/fsqrt_nr_seq.sv - sequential IEEE-754 single sqrt / rsqrt via table seed and Newton steps
module fsqrt_nr_seq #(
    parameter int TABLE_BITS = 7,
    parameter int NR_ITERS   = 2,
    parameter int FRAC_W     = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_rsqrt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_invalid,
    output logic        out_divzero
);
    localparam int W     = FRAC_W + 2;
    localparam int TBL_N = 1 << TABLE_BITS;
    localparam int IW    = TABLE_BITS - 1;
    localparam logic [1:0]    ITER_LAST = 2'(NR_ITERS - 1);
    localparam logic [W-1:0]  THREE     = {2'b11, {FRAC_W{1'b0}}};
    localparam logic [FRAC_W:0] ONE_V   = {1'b1, {FRAC_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_ITER_A, S_ITER_B, S_FINAL, S_ROUND, S_DONE
    } state_t;

    state_t r_state, w_next;

    // Seed = floor(2^FRAC_W / sqrt(midpoint)), computed as isqrt(2^(2F+sh) / M)
    // where midpoint = M / 2^sh and M = 2^TABLE_BITS + 2k + 1.
    function automatic logic [W-1:0] seed_val(input int idx);
        logic [127:0] num, den, root, trial;
        int k, sh;
        k    = idx % (1 << IW);
        sh   = (idx >= (1 << IW)) ? TABLE_BITS - 1 : TABLE_BITS;
        den  = 128'((1 << TABLE_BITS) + 2 * k + 1);
        num  = (128'd1 << (2 * FRAC_W + sh)) / den;
        root = '0;
        for (int b = 47; b >= 0; b--) begin
            trial = root | (128'd1 << b);
            if (trial * trial <= num) root = trial;
        end
        return root[W-1:0];
    endfunction

    function automatic logic [W-1:0] mulq(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[FRAC_W+W-1:FRAC_W];
    endfunction

    function automatic logic [W-1:0] mulq_half(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[FRAC_W+W:FRAC_W+1];
    endfunction

    logic [W-1:0] w_seed_tab [TBL_N];
    for (genvar gi = 0; gi < TBL_N; gi++) begin : g_seed
        localparam logic [W-1:0] SEED = seed_val(gi);
        assign w_seed_tab[gi] = SEED;
    end

    logic [31:0]     r_in;
    logic            r_rsqrt;
    logic [W-1:0]    r_m, r_y, r_u;
    logic [FRAC_W:0] r_v;
    logic [7:0]      r_ehalf;
    logic [1:0]      r_iter;
    logic            r_spec, r_spec_inv, r_spec_dz;
    logic [31:0]     r_spec_val;
    logic [31:0]     r_out;
    logic            r_inv, r_dz;

    logic                  w_sign, w_odd, w_zero, w_allone, w_nan, w_inf;
    logic [7:0]            w_exp;
    logic [22:0]           w_fr;
    logic [W-1:0]          w_m1, w_m, w_my;
    logic [TABLE_BITS-1:0] w_idx;
    logic signed [9:0]     w_eadj;
    logic                  w_spec, w_spec_inv, w_spec_dz;
    logic [31:0]           w_spec_val;

    assign w_sign   = r_in[31];
    assign w_exp    = r_in[30:23];
    assign w_fr     = r_in[22:0];
    assign w_odd    = ~w_exp[0];
    assign w_zero   = (w_exp == 8'h00);
    assign w_allone = (w_exp == 8'hFF);
    assign w_nan    = w_allone & (|w_fr);
    assign w_inf    = w_allone & ~(|w_fr);
    assign w_m1     = {2'b01, w_fr, {(FRAC_W-23){1'b0}}};
    assign w_m      = w_odd ? {w_m1[W-2:0], 1'b0} : w_m1;
    assign w_idx    = {w_odd, w_fr[22 -: IW]};
    assign w_eadj   = $signed({2'b00, w_exp}) - 10'sd127 - $signed({9'd0, w_odd});
    assign w_my     = mulq(r_m, r_y);

    // Denormals fall into the zero branch, which is the flush-to-zero.
    always_comb begin
        w_spec     = 1'b1;
        w_spec_val = 32'h0000_0000;
        w_spec_inv = 1'b0;
        w_spec_dz  = 1'b0;
        if (w_nan) begin
            w_spec_val = 32'h7FC0_0000;
        end else if (w_zero) begin
            w_spec_val = r_rsqrt ? {w_sign, 8'hFF, 23'd0} : {w_sign, 31'd0};
            w_spec_dz  = r_rsqrt;
        end else if (w_sign) begin
            w_spec_val = 32'h7FC0_0000;
            w_spec_inv = 1'b1;
        end else if (w_inf) begin
            w_spec_val = r_rsqrt ? 32'h0000_0000 : 32'h7F80_0000;
        end else begin
            w_spec     = 1'b0;
        end
    end

    logic        w_hi, w_g, w_st;
    logic [23:0] w_mant;
    logic [24:0] w_rnd;
    logic [22:0] w_fout;
    logic [7:0]  w_eout;

    // r_v is in [1,2) (hi) or [0.5,1) for rsqrt; the latter costs one exponent step.
    assign w_hi   = r_v[FRAC_W];
    assign w_mant = w_hi ? r_v[FRAC_W -: 24] : r_v[FRAC_W-1 -: 24];
    assign w_g    = w_hi ? r_v[FRAC_W-24] : r_v[FRAC_W-25];
    assign w_st   = w_hi ? (|r_v[FRAC_W-25:0]) : (|r_v[FRAC_W-26:0]);
    assign w_rnd  = {1'b0, w_mant} + {24'd0, w_g & (w_st | w_mant[0])};
    assign w_fout = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
    assign w_eout = (r_rsqrt ? (8'd127 - r_ehalf) : (8'd127 + r_ehalf))
                    - {7'd0, ~w_hi} + {7'd0, w_rnd[24]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_SEED;
            end
            S_SEED:   w_next = S_ITER_A;
            S_ITER_A: w_next = S_ITER_B;
            S_ITER_B: w_next = (r_iter == ITER_LAST) ? S_FINAL : S_ITER_A;
            S_FINAL:  w_next = S_ROUND;
            S_ROUND:  w_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in       <= '0;
            r_rsqrt    <= 1'b0;
            r_m        <= '0;
            r_y        <= '0;
            r_u        <= '0;
            r_v        <= '0;
            r_ehalf    <= '0;
            r_iter     <= '0;
            r_spec     <= 1'b0;
            r_spec_inv <= 1'b0;
            r_spec_dz  <= 1'b0;
            r_spec_val <= '0;
            r_out      <= '0;
            r_inv      <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in    <= in_data;
                        r_rsqrt <= in_rsqrt;
                    end
                end
                S_SEED: begin
                    r_m        <= w_m;
                    r_y        <= w_seed_tab[w_idx];
                    r_ehalf    <= 8'(w_eadj >>> 1);
                    r_iter     <= '0;
                    r_spec     <= w_spec;
                    r_spec_val <= w_spec_val;
                    r_spec_inv <= w_spec_inv;
                    r_spec_dz  <= w_spec_dz;
                end
                S_ITER_A: r_u <= mulq(w_my, r_y);
                S_ITER_B: begin
                    r_y    <= mulq_half(r_y, THREE - r_u);
                    r_iter <= r_iter + 2'd1;
                end
                S_FINAL: begin
                    // m*y can land a hair below 1.0 when m is exactly 1; sqrt(m) >= 1 always.
                    if (r_rsqrt)                        r_v <= r_y[FRAC_W:0];
                    else if (w_my[W-1:FRAC_W] == 2'b00) r_v <= ONE_V;
                    else                                r_v <= w_my[FRAC_W:0];
                end
                S_ROUND: begin
                    r_out <= r_spec ? r_spec_val : {1'b0, w_eout, w_fout};
                    r_inv <= r_spec_inv;
                    r_dz  <= r_spec_dz;
                end
                default: ;
            endcase
        end
    end

    assign out_data    = r_out;
    assign out_invalid = r_inv;
    assign out_divzero = r_dz;
endmodule

// File: tb/tb_fsqrt_nr_seq.sv
// tb/tb_fsqrt_nr_seq.sv - self-checking bench for fsqrt_nr_seq against a real-arithmetic model
module tb_fsqrt_nr_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, in_rsqrt, out_ready, sel3;
    logic        in_valid_a, in_valid_b;
    logic [31:0] in_data;
    logic        in_ready_a, out_valid_a, inv_a, dz_a;
    logic        in_ready_b, out_valid_b, inv_b, dz_b;
    logic [31:0] out_a, out_b;
    logic        s_in_ready, s_out_valid, s_inv, s_dz;
    logic [31:0] s_out;
    int          vectors = 0;
    int          errors  = 0;

    fsqrt_nr_seq #(.TABLE_BITS(7), .NR_ITERS(2), .FRAC_W(32)) u_dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data), .in_rsqrt(in_rsqrt), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_a), .out_invalid(inv_a), .out_divzero(dz_a));

    fsqrt_nr_seq #(.TABLE_BITS(7), .NR_ITERS(3), .FRAC_W(32)) u_dut3 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data), .in_rsqrt(in_rsqrt), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_b), .out_invalid(inv_b), .out_divzero(dz_b));

    assign s_in_ready  = sel3 ? in_ready_b  : in_ready_a;
    assign s_out_valid = sel3 ? out_valid_b : out_valid_a;
    assign s_out       = sel3 ? out_b       : out_a;
    assign s_inv       = sel3 ? inv_b       : inv_a;
    assign s_dz        = sel3 ? dz_b        : dz_a;

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        logic [7:0]  fe;
        logic [24:0] mr;
        b  = $realtobits(r);
        fe = 8'(b[62:52] - 11'd896);
        mr = {2'b01, b[51:29]} + ((b[28] & ((|b[27:0]) | b[29])) ? 25'd1 : 25'd0);
        if (mr[24]) begin
            fe = fe + 8'd1;
            mr = mr >> 1;
        end
        return {1'b0, fe, mr[22:0]};
    endfunction

    function automatic void ref_op(input logic [31:0] x, input logic rsq, output logic [31:0] r,
                                   output logic inv, output logic dz, output logic approx);
        logic s;
        logic [7:0] e;
        logic [22:0] f;
        real xv, rv;
        s = x[31]; e = x[30:23]; f = x[22:0];
        inv = 1'b0; dz = 1'b0; approx = 1'b0;
        if (e == 8'hFF && f != 0) r = 32'h7FC00000;
        else if (e == 8'h00) begin
            r  = rsq ? {s, 8'hFF, 23'd0} : {s, 31'd0};
            dz = rsq;
        end else if (s) begin
            r = 32'h7FC00000; inv = 1'b1;
        end else if (e == 8'hFF) r = rsq ? 32'h0 : 32'h7F800000;
        else begin
            xv = $bitstoreal({1'b0, 11'({3'b000, e} + 11'd896), f, 29'd0});
            rv = rsq ? 1.0 / $sqrt(xv) : $sqrt(xv);
            r  = real_to_f32(rv);
            approx = 1'b1;
        end
    endfunction

    task automatic do_op(input logic [31:0] x, input logic rsq, output logic [31:0] res,
                         output logic inv, output logic dz, output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!s_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_data = x; in_rsqrt = rsq;
        in_valid_a = ~sel3; in_valid_b = sel3;
        @(posedge clk); #1;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_data = $urandom(); in_rsqrt = 1'($urandom_range(0, 1));
        lat = 0;
        while (!s_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = s_out; inv = s_inv; dz = s_dz;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic saw;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_a !== 32'h0 || inv_a !== 1'b0 || dz_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h inv=%b dz=%b want 1 0 00000000 0 0",
                     in_ready_a, out_valid_a, out_a, inv_a, dz_a);
        end
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        in_data = 32'h40800000; in_rsqrt = 1'b0; in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b0;
        #1;
        vectors++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: vld=%b rdy=%b want 0 1", out_valid_a, in_ready_a);
        end
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: vld=%b rdy=%b want 0 1", out_valid_a, in_ready_a);
        end
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            saw |= out_valid_a;
        end
        vectors++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: out_valid seen=%b want 0", saw);
        end
    endtask

    task automatic test_exact();
        logic [31:0] res, want;
        logic inv, dz;
        int lat, d;
        real sc;
        do_op(32'h40800000, 1'b0, res, inv, dz, lat);
        vectors++;
        if (res !== 32'h40000000 || inv !== 1'b0 || dz !== 1'b0 || lat != 7) begin
            errors++;
            $display("FAIL sqrt4: got %h inv=%b dz=%b lat=%0d want 40000000 0 0 7", res, inv, dz, lat);
        end
        do_op(32'h40800000, 1'b1, res, inv, dz, lat);
        vectors++;
        if (res !== 32'h3F000000 || inv !== 1'b0 || dz !== 1'b0 || lat != 7) begin
            errors++;
            $display("FAIL rsqrt4: got %h inv=%b dz=%b lat=%0d want 3f000000 0 0 7", res, inv, dz, lat);
        end
        do_op(32'h40000000, 1'b0, res, inv, dz, lat);
        d = int'(res) - int'(32'h3FB504F3);
        vectors++;
        if (d > 1 || d < -1 || lat != 7) begin
            errors++;
            $display("FAIL sqrt2: got %h lat=%0d want 3fb504f3 +/-1 lat 7", res, lat);
        end
        for (int i = 0; i < 40; i++) begin
            int n, j;
            n  = $urandom_range(1, 4095);
            j  = $urandom_range(0, 60) - 30;
            sc = 1.0;
            for (int k = 0; k < (j < 0 ? -j : j); k++) sc = (j < 0) ? sc * 0.5 : sc * 2.0;
            want = real_to_f32(real'(n) * sc);
            do_op(real_to_f32(real'(n) * real'(n) * sc * sc), 1'b0, res, inv, dz, lat);
            vectors++;
            if (res !== want || inv !== 1'b0 || dz !== 1'b0) begin
                errors++;
                $display("FAIL exact_square n=%0d j=%0d: got %h want %h", n, j, res, want);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] xs [9] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 32'h00000001, 32'h80000000,
                                32'h7F800000, 32'h7FC12345, 32'hFF800000, 32'h80000001};
        logic        rq [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] ws [9] = '{32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000, 32'h80000000,
                                32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h80000000};
        logic        wi [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        wd [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] res;
        logic inv, dz;
        int lat;
        for (int i = 0; i < 9; i++) begin
            do_op(xs[i], rq[i], res, inv, dz, lat);
            vectors++;
            if (res !== ws[i] || inv !== wi[i] || dz !== wd[i] || lat != 7) begin
                errors++;
                $display("FAIL special %h rsqrt=%b: got %h inv=%b dz=%b lat=%0d want %h %b %b 7",
                         xs[i], rq[i], res, inv, dz, lat, ws[i], wi[i], wd[i]);
            end
        end
    endtask

    task automatic test_handshake();
        int n;
        out_ready = 1'b0;
        @(negedge clk);
        in_data = 32'h41100000; in_rsqrt = 1'b0; in_valid_a = 1'b1;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        n = 0;
        while (!out_valid_a && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid_a = 1'b1; in_data = $urandom(); in_rsqrt = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            vectors++;
            if (out_valid_a !== 1'b1 || out_a !== 32'h40400000 || in_ready_a !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: vld=%b data=%h rdy=%b want 1 40400000 0",
                         i, out_valid_a, out_a, in_ready_a);
            end
        end
        @(negedge clk);
        in_data = 32'h41800000; in_rsqrt = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL release: vld=%b rdy=%b want 0 1", out_valid_a, in_ready_a);
        end
        @(posedge clk); #1;
        in_valid_a = 1'b0; in_data = 32'h3F800000;
        n = 0;
        while (!out_valid_a && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (out_a !== 32'h40800000 || n != 7) begin
            errors++;
            $display("FAIL follow_op: got %h lat=%0d want 40800000 lat 7", out_a, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input logic use3, input int count);
        logic [31:0] x, res, want;
        logic rsq, inv, dz, winv, wdz, approx;
        int lat, d, lat_req;
        sel3    = use3;
        lat_req = use3 ? 9 : 7;
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 19) < 18) x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom())};
            else                            x = $urandom();
            rsq = 1'($urandom_range(0, 1));
            do_op(x, rsq, res, inv, dz, lat);
            ref_op(x, rsq, want, winv, wdz, approx);
            d = int'(res) - int'(want);
            vectors++;
            if (inv !== winv || dz !== wdz || (approx ? (d > 1 || d < -1) : (res !== want))) begin
                errors++;
                $display("FAIL random nr%0d x=%h rsqrt=%b: got %h inv=%b dz=%b want %h inv=%b dz=%b",
                         use3 ? 3 : 2, x, rsq, res, inv, dz, want, winv, wdz);
            end
            vectors++;
            if (lat != lat_req) begin
                errors++;
                $display("FAIL latency nr%0d x=%h: got %0d want %0d", use3 ? 3 : 2, x, lat, lat_req);
            end
        end
        sel3 = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; sel3 = 1'b0; out_ready = 1'b1;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_data = 32'h0; in_rsqrt = 1'b0;
        test_reset();
        test_exact();
        test_specials();
        test_handshake();
        test_random(1'b0, 2000);
        test_random(1'b1, 800);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
